// File: rtl/regfile_dump_reader.sv
// Debug dump engine: halts the CPU, walks FIRST_REG..LAST_REG over the register-file
// read port and streams {addr,data} beats on valid/ready. Optional: REGDUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cpu_halt,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_csum,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_READ,
    S_SEND,
    S_FIN
`ifdef REGDUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                halt_q, halt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic                out_csum_q, out_csum_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  // Next-state and next-output computation for the dump walk.
  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    halt_d      = halt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
    out_csum_d  = out_csum_q;
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          halt_d    = 1'b1;
          busy_d    = 1'b1;
          rf_addr_d = FIRST_A;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d    = {DATA_W{1'b0}};
`endif
          state_d   = S_QUIESCE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_QUIESCE: state_d = S_READ;
      S_READ: begin
        out_data_d  = rf_data;
        out_addr_d  = rf_addr_q;
        out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        csum_d      = csum_q ^ rf_data;
`else
        out_last_d  = (rf_addr_q == LAST_A);
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          // Compare before increment so LAST_REG at the top of the range never wraps.
          if (rf_addr_q < LAST_A) begin
            rf_addr_d = rf_addr_q + ONE_A;
            state_d   = S_READ;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d   = S_CSUM;
`else
            done_d    = 1'b1;
            halt_d    = 1'b0;
            busy_d    = 1'b0;
            state_d   = S_FIN;
`endif
          end
        end else begin
          state_d = S_SEND;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      // First CSUM cycle loads the beat, keeping the one-beat-per-two-cycles rate.
      S_CSUM: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_addr_d  = {ADDR_W{1'b0}};
          out_data_d  = csum_q;
          out_csum_d  = 1'b1;
          out_last_d  = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_csum_d  = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          halt_d      = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_FIN;
        end else begin
          state_d     = S_CSUM;
        end
      end
`endif
      S_FIN: state_d = S_IDLE;
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        halt_d      = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset drops any pending beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rf_addr_q   <= {ADDR_W{1'b0}};
      out_valid_q <= 1'b0;
      out_addr_q  <= {ADDR_W{1'b0}};
      out_data_q  <= {DATA_W{1'b0}};
      out_last_q  <= 1'b0;
      halt_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      out_csum_q  <= 1'b0;
      csum_q      <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      halt_q      <= halt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      out_csum_q  <= out_csum_d;
      csum_q      <= csum_d;
`endif
    end
  end

  assign cpu_halt  = halt_q;
  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef REGDUMP_CHECKSUM_EN
  assign out_csum  = out_csum_q;
`else
  assign out_csum  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader; expected beat streams come
// from a queue built directly from the register array contents.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        cpu_halt, out_valid, out_last, out_csum, busy, done;
  logic [4:0]  rf_addr, out_addr;
  logic [31:0] rf_data, out_data;

  logic        start1 = 1'b0;
  logic        ready1 = 1'b1;
  logic        halt1, valid1, last1, csum1, busy1, done1;
  logic [4:0]  rf_addr1, addr1;
  logic [31:0] rf_data1, data1;

  logic [31:0] regs [32];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rf_data  = regs[rf_addr];
  assign rf_data1 = regs[rf_addr1];

  regfile_dump_reader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_halt(cpu_halt), .rf_addr(rf_addr),
    .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .out_csum(out_csum), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.FIRST_REG(12), .LAST_REG(12)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start1), .cpu_halt(halt1), .rf_addr(rf_addr1),
    .rf_data(rf_data1), .out_valid(valid1), .out_ready(ready1), .out_addr(addr1),
    .out_data(data1), .out_last(last1), .out_csum(csum1), .busy(busy1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h11;
    regs[12] = 32'h38;
  endtask

  task automatic load_random();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  // One full dump; negative arguments disable stall / restart / reset injection.
  task automatic run_dump(input bit rnd_ready, input int stall_addr, input int restart_beat,
                          input int reset_addr);
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    logic [31:0] x;
    logic [4:0]  h_a, ea;
    logic [31:0] h_d, ed;
    int beats, dones, stall_cnt, total;
    bit held, finished;
    x = 32'h0;
    for (int a = 1; a <= 31; a++) begin
      qa.push_back(5'(a));
      qd.push_back(regs[a]);
      x ^= regs[a];
    end
    if (CS) begin
      qa.push_back(5'd0);
      qd.push_back(x);
    end
    total = qa.size();
    beats = 0; dones = 0; stall_cnt = 0; held = 1'b0; finished = 1'b0;

    @(posedge clk); #1 start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    check_eq("accept_halt", cpu_halt, 1);
    check_eq("accept_busy", busy, 1);
    check_eq("accept_rf_addr", rf_addr, 1);
    @(posedge clk); #1 check_eq("latency_not_yet", out_valid, 0);
    @(posedge clk); #1 check_eq("latency_valid", out_valid, 1);

    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (reset_addr >= 0 && out_valid && out_addr == 5'(reset_addr)) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_halt", cpu_halt, 0);
        check_eq("rst_busy", busy, 0);
        @(posedge clk); #1;
        check_eq("rst_no_done", done, 0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        return;
      end
      if (stall_addr >= 0 && out_valid && out_addr == 5'(stall_addr) && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = (restart_beat >= 0 && beats == restart_beat) ? 1'b1 : 1'b0;

      @(negedge clk);
      if (held) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_addr", out_addr, h_a);
        check_eq("hold_data", out_data, h_d);
      end
      held = out_valid && !out_ready;
      h_a  = out_addr;
      h_d  = out_data;
      if (out_valid && out_ready) begin
        if (qa.size() == 0) begin
          check_eq("extra_beat", beats + 1, total);
        end else begin
          ea = qa.pop_front();
          ed = qd.pop_front();
          check_eq("beat_addr", out_addr, ea);
          check_eq("beat_data", out_data, ed);
          check_eq("beat_last", out_last, qa.size() == 0);
          check_eq("beat_csum", out_csum, CS && qa.size() == 0);
        end
        beats++;
      end
      if (done) begin
        dones++;
        finished = 1'b1;
        check_eq("done_halt", cpu_halt, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_beats", beats, total);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check_eq("dump_finished", finished, 1);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("halt_after", cpu_halt, 0);
    check_eq("done_count", dones, 1);
    check_eq("beats_left", qa.size(), 0);
    if (stall_addr >= 0) check_eq("stall_cycles", stall_cnt, 5);
  endtask

  task automatic run_single();
    int seen;
    bit fin;
    seen = 0; fin = 1'b0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (valid1 && ready1) begin
        seen++;
        if (seen == 1) begin
          check_eq("one_addr", addr1, 12);
          check_eq("one_data", data1, regs[12]);
          check_eq("one_last", last1, !CS);
          check_eq("one_csum", csum1, 0);
        end else begin
          check_eq("one_csum_addr", addr1, 0);
          check_eq("one_csum_data", data1, regs[12]);
          check_eq("one_csum_last", last1, 1);
          check_eq("one_csum_flag", csum1, 1);
        end
      end
      if (done1) begin
        fin = 1'b1;
        check_eq("one_beats", seen, CS ? 2 : 1);
      end
      @(posedge clk); #1;
    end
    check_eq("one_finished", fin, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    #1;
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_halt", cpu_halt, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_rf_addr", rf_addr, 0);
    check_eq("reset_last", out_last, 0);
    check_eq("reset_csum", out_csum, 0);
    check_eq("reset_data", out_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    load_pattern();
    run_dump(1'b0, -1, -1, -1);
    run_dump(1'b0, 7, -1, -1);
    run_dump(1'b0, -1, 10, -1);
    run_dump(1'b0, -1, -1, 15);
    run_dump(1'b0, -1, -1, -1);
    run_single();
    for (int k = 0; k < 3; k++) begin
      load_random();
      run_dump(1'b1, (k == 1) ? 20 : -1, (k == 2) ? 5 : -1, -1);
    end
    load_random();
    run_single();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
